// File: rtl/kb_pkg.sv
// Shared types and helpers for the keypad matrix scanner and the calculator FSM
// that consumes its key codes.
package kb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HELD  = 2'd1,
    S_MULTI = 2'd2
  } kb_state_t;

  // Width of a linear key code row*COLS+col; never narrower than one bit.
  function automatic int kw(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Nibble i is the calculator code for 4x4 key i:
  // 0-9 digits, A '+', B '-', C '*', D '/', E '=', F clear.
  localparam logic [63:0] KEY_BCD_4X4 = 64'hDE0F_C987_B654_A321;

  function automatic logic [3:0] key_bcd_4x4(input logic [3:0] code);
    return KEY_BCD_4X4[{code, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/kb_frame_debounce.sv
// Whole-frame debouncer: a matrix snapshot is accepted once it has been seen
// on DEBOUNCE_SCANS consecutive frames.
module kb_frame_debounce
  import kb_pkg::*;
#(
  parameter int N              = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         frame_valid,
  input  logic [N-1:0] frame,
  output logic [N-1:0] deb_state,
  output logic         deb_tick
);

  localparam int CNTW = $clog2(DEBOUNCE_SCANS);
  localparam logic [CNTW-1:0] CNT_TOP = CNTW'(DEBOUNCE_SCANS - 1);

  logic [N-1:0]    prev_reg;
  logic [CNTW-1:0] cnt_reg;
  logic [CNTW-1:0] cnt_next;
  logic            same;

  assign same = (frame == prev_reg);

  // The count saturates so a long-stable matrix keeps refreshing deb_state.
  always_comb begin
    cnt_next = cnt_reg;
    if (!same) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_TOP) begin
      cnt_next = cnt_reg + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_reg  <= '0;
      cnt_reg   <= '0;
      deb_state <= '0;
      deb_tick  <= 1'b0;
    end else if (clr) begin
      prev_reg  <= '0;
      cnt_reg   <= '0;
      deb_state <= '0;
      deb_tick  <= 1'b0;
    end else begin
      deb_tick <= frame_valid;
      if (frame_valid) begin
        prev_reg <= frame;
        cnt_reg  <= cnt_next;
        if (cnt_next == CNT_TOP) begin
          deb_state <= frame;
        end
      end
    end
  end

endmodule

// File: rtl/kb_matrix_scanner.sv
// ROWS x COLS key matrix scanner: column drive, row sampling, frame debounce,
// single-key FSM with optional auto-repeat, and a valid/ready key-code output.
module kb_matrix_scanner
  import kb_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 256,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_EN      = 0,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8,
  localparam int KW            = kw(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            multi_key,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = 16;

  logic [ROWS-1:0] row_meta_reg, row_sync_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_meta_reg <= '1;
      row_sync_reg <= '1;
    end else begin
      row_meta_reg <= row_in;
      row_sync_reg <= row_meta_reg;
    end
  end

  // active_reg delays scanning by one cycle after en rises so column 0 gets a full slot.
  logic          active_reg;
  logic [DW-1:0] div_reg;
  logic [CW-1:0] col_reg;
  logic          slot_last, frame_end;

  assign slot_last = active_reg && en && (div_reg == DW'(SCAN_DIV - 1));
  assign frame_end = slot_last && (col_reg == CW'(COLS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_reg <= 1'b0;
      div_reg    <= '0;
      col_reg    <= '0;
    end else begin
      active_reg <= en;
      if (!en) begin
        div_reg <= '0;
        col_reg <= '0;
      end else if (active_reg) begin
        if (slot_last) begin
          div_reg <= '0;
          col_reg <= frame_end ? '0 : col_reg + CW'(1);
        end else begin
          div_reg <= div_reg + DW'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col_drive
    assign col_out[gi] = !(active_reg && (col_reg == CW'(gi)));
  end

  // frame_cur merges the column being sampled into the partial snapshot, so at
  // frame_end it already holds the complete matrix (1 = key closed).
  logic [N-1:0] snap_reg, frame_cur;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      assign frame_cur[gi*COLS+gj] = (slot_last && (col_reg == CW'(gj))) ?
                                     !row_sync_reg[gi] : snap_reg[gi*COLS+gj];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snap_reg <= '0;
    end else if (!en) begin
      snap_reg <= '0;
    end else begin
      snap_reg <= frame_cur;
    end
  end

  logic [N-1:0] deb_state;
  logic         deb_tick;

  kb_frame_debounce #(
    .N              (N),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .resetn      (resetn),
    .clr         (!en),
    .frame_valid (frame_end),
    .frame       (frame_cur),
    .deb_state   (deb_state),
    .deb_tick    (deb_tick)
  );

  logic          keys_none, keys_one;
  logic [KW-1:0] deb_code;

  assign keys_none = (deb_state == '0);
  assign keys_one  = !keys_none && ((deb_state & (deb_state - N'(1))) == '0);

  always_comb begin
    deb_code = '0;
    for (int i = 0; i < N; i++) begin
      if (deb_state[i]) begin
        deb_code = KW'(i);
      end
    end
  end

  kb_state_t     state_reg, state_next;
  logic [KW-1:0] held_code_reg, held_code_next;
  logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
  logic          ev_fire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      held_code_reg <= '0;
      rep_cnt_reg   <= '0;
    end else if (!en) begin
      state_reg     <= S_IDLE;
      held_code_reg <= '0;
      rep_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      held_code_reg <= held_code_next;
      rep_cnt_reg   <= rep_cnt_next;
    end
  end

  // rep_cnt_reg counts down the frames left until the next repeat event.
  always_comb begin
    state_next     = state_reg;
    held_code_next = held_code_reg;
    rep_cnt_next   = rep_cnt_reg;
    ev_fire        = 1'b0;
    if (deb_tick) begin
      case (state_reg)
        S_IDLE: begin
          if (keys_one) begin
            ev_fire        = 1'b1;
            state_next     = S_HELD;
            held_code_next = deb_code;
            rep_cnt_next   = RW'(REPEAT_DELAY);
          end else if (!keys_none) begin
            state_next = S_MULTI;
          end
        end
        S_HELD: begin
          if (keys_none) begin
            state_next = S_IDLE;
          end else if (!keys_one || (deb_code != held_code_reg)) begin
            state_next = S_MULTI;
          end else if (REPEAT_EN != 0) begin
            if (rep_cnt_reg <= RW'(1)) begin
              ev_fire      = 1'b1;
              rep_cnt_next = RW'(REPEAT_RATE);
            end else begin
              rep_cnt_next = rep_cnt_reg - RW'(1);
            end
          end
        end
        S_MULTI: begin
          if (keys_none) begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign key_held  = (state_reg == S_HELD);
  assign multi_key = (state_reg == S_MULTI);

  // An event loads if the slot is free or is being freed this very cycle;
  // otherwise it is dropped and the pending code is preserved.
  logic ev_accept;
  assign ev_accept = ev_fire && (!key_valid || key_ready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (ev_accept) begin
        key_valid <= 1'b1;
        key_code  <= deb_code;
      end else if (key_ready) begin
        key_valid <= 1'b0;
      end
      if (ev_fire && !ev_accept) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kb_matrix_scanner.sv
// Self-checking bench for kb_matrix_scanner: a plain instance and an auto-repeat
// instance, each driven by a behavioural key matrix.
module tb_kb_matrix_scanner;

  localparam int R = 4;
  localparam int C = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn, en;
  logic [R-1:0] row_a, row_b;
  logic [C-1:0] col_a, col_b;
  logic [3:0]   code_a, code_b;
  logic         valid_a, valid_b, ready_a, ready_b;
  logic         held_a, held_b, multi_a, multi_b, ovf_a, ovf_b;
  logic         ovf_clr_a, ovf_clr_b;
  logic [R*C-1:0] keys_a, keys_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int xfer_a = 0;
  int rep_t0 = 0;
  int exp_code_a, exp_frame_b;
  int exp_q[$];
  int exp_qb[$];

  typedef struct {
    int row;
    int col;
    int code;
  } vec_t;
  vec_t vecs[6];

  // A closed key pulls its row low while its column is driven low.
  always_comb begin
    for (int r = 0; r < R; r++) begin
      row_a[r] = ~|(keys_a[r*C +: C] & ~col_a);
      row_b[r] = ~|(keys_b[r*C +: C] & ~col_b);
    end
  end

  kb_matrix_scanner #(
    .ROWS(R), .COLS(C), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
    .REPEAT_EN(0), .REPEAT_DELAY(32), .REPEAT_RATE(8)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en), .row_in(row_a), .col_out(col_a),
    .key_code(code_a), .key_valid(valid_a), .key_ready(ready_a),
    .key_held(held_a), .multi_key(multi_a), .overflow(ovf_a), .ovf_clr(ovf_clr_a)
  );

  kb_matrix_scanner #(
    .ROWS(R), .COLS(C), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
    .REPEAT_EN(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut_rep (
    .clk(clk), .resetn(resetn), .en(en), .row_in(row_b), .col_out(col_b),
    .key_code(code_b), .key_valid(valid_b), .key_ready(ready_b),
    .key_held(held_b), .multi_key(multi_b), .overflow(ovf_b), .ovf_clr(ovf_clr_b)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (resetn && valid_a && ready_a) begin
      xfer_a++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_a: unexpected event code=%0d", code_a);
      end else begin
        exp_code_a = exp_q.pop_front();
        if (code_a !== 4'(exp_code_a)) begin
          errors++;
          $display("FAIL event_a: code=%0d expected=%0d", code_a, exp_code_a);
        end else begin
          $display("event_a code=%0d ok", code_a);
        end
      end
    end
  end

  // Repeat events are checked by their distance in frames from the first one.
  always @(negedge clk) begin
    if (resetn && valid_b && ready_b) begin
      checks++;
      if (exp_qb.size() == 0) begin
        errors++;
        $display("FAIL event_b: unexpected event code=%0d", code_b);
      end else begin
        exp_frame_b = exp_qb.pop_front();
        if (exp_frame_b == 0) rep_t0 = cyc;
        if ((cyc - rep_t0) != 16 * exp_frame_b || code_b !== 4'd10) begin
          errors++;
          $display("FAIL event_b: code=%0d at cycle offset %0d, expected code=10 at offset %0d",
                   code_b, cyc - rep_t0, 16 * exp_frame_b);
        end else begin
          $display("event_b code=%0d frame=%0d ok", code_b, exp_frame_b);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit probe(input int sel);
    case (sel)
      0:       return valid_a;
      1:       return !held_a;
      2:       return multi_a;
      3:       return !multi_a;
      4:       return ovf_a;
      5:       return valid_b;
      6:       return !held_b;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int limit, input string name, output int n);
    n = 0;
    while (!probe(sel) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!probe(sel)) begin
      errors++;
      $display("FAIL %s: condition not reached, waited %0d cycles, limit %0d", name, n, limit);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    resetn = 1'b0; en = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1;
    ovf_clr_a = 1'b0; ovf_clr_b = 1'b0;
    keys_a = '0; keys_b = '0;
    vecs[0] = '{2, 1, 9};
    vecs[1] = '{0, 0, 0};
    vecs[2] = '{1, 2, 6};
    vecs[3] = '{3, 3, 15};
    vecs[4] = '{3, 0, 12};
    vecs[5] = '{0, 3, 3};

    #12;
    chk("reset_col_out", col_a, 4'hF);
    chk("reset_valid", valid_a, 0);
    chk("reset_code", code_a, 0);
    chk("reset_held", held_a, 0);
    chk("reset_multi", multi_a, 0);
    chk("reset_overflow", ovf_a, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick(40);

    // Single keys, one at a time.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].code);
      keys_a[vecs[i].row*C + vecs[i].col] = 1'b1;
      wait_for(0, 70, "press_valid", n);
      chk("press_latency_le_66", n <= 66, 1);
      tick(20);
      chk("held_while_down", held_a, 1);
      keys_a = '0;
      wait_for(1, 80, "release_held", n);
    end

    // Bouncing key: alternating frames, then steady.
    base = xfer_a;
    exp_q.push_back(3);
    for (int k = 0; k < 5; k++) begin
      keys_a[3] = (k % 2 == 0);
      tick(16);
    end
    keys_a[3] = 1'b1;
    wait_for(0, 80, "bounce_valid", n);
    tick(2);
    keys_a = '0;
    wait_for(1, 80, "bounce_release", n);
    chk("bounce_one_event", xfer_a - base, 1);

    // Overflow: second event dropped while the first is pending.
    ready_a = 1'b0;
    exp_q.push_back(4);
    keys_a[4] = 1'b1;
    wait_for(0, 70, "ovf_first_valid", n);
    keys_a = '0;
    wait_for(1, 80, "ovf_release_first", n);
    keys_a[7] = 1'b1;
    wait_for(4, 80, "ovf_set", n);
    chk("ovf_code_kept", code_a, 4);
    chk("ovf_valid_kept", valid_a, 1);
    keys_a = '0;
    wait_for(1, 80, "ovf_release_second", n);
    chk("ovf_sticky", ovf_a, 1);
    ovf_clr_a = 1'b1;
    tick(1);
    ovf_clr_a = 1'b0;
    chk("ovf_cleared", ovf_a, 0);
    ready_a = 1'b1;
    tick(2);
    chk("ovf_valid_fell", valid_a, 0);

    // Two keys together: MULTI, no event until all released.
    base = xfer_a;
    keys_a[0] = 1'b1;
    keys_a[5] = 1'b1;
    wait_for(2, 80, "multi_set", n);
    chk("multi_not_held", held_a, 0);
    tick(48);
    chk("multi_still_set", multi_a, 1);
    chk("multi_no_event", xfer_a - base, 0);
    keys_a = '0;
    wait_for(3, 80, "multi_clear", n);
    exp_q.push_back(15);
    keys_a[15] = 1'b1;
    wait_for(0, 70, "after_multi_valid", n);
    keys_a = '0;
    wait_for(1, 80, "after_multi_release", n);

    // en low keeps a pending event, idles the scan and restarts at column 0.
    ready_a = 1'b0;
    exp_q.push_back(6);
    keys_a[6] = 1'b1;
    wait_for(0, 70, "en_valid", n);
    en = 1'b0;
    tick(2);
    chk("en_off_col_out", col_a, 4'hF);
    chk("en_off_held", held_a, 0);
    chk("en_off_valid_kept", valid_a, 1);
    chk("en_off_code_kept", code_a, 6);
    keys_a = '0;
    en = 1'b1;
    tick(1);
    chk("en_on_col0", col_a, 4'hE);
    ready_a = 1'b1;
    tick(2);
    chk("en_valid_consumed", valid_a, 0);

    // Auto-repeat: events at frames 0, 4, 6, 8, 10 of the hold.
    foreach (vecs[i]) if (i < 0) exp_qb.push_back(0);
    exp_qb.push_back(0);
    exp_qb.push_back(4);
    exp_qb.push_back(6);
    exp_qb.push_back(8);
    exp_qb.push_back(10);
    keys_b[10] = 1'b1;
    wait_for(5, 70, "rep_first_valid", n);
    tick(20);
    chk("rep_held", held_b, 1);
    tick(115);
    keys_b = '0;
    wait_for(6, 80, "rep_release", n);
    tick(20);
    chk("rep_all_events", exp_qb.size(), 0);

    // Asynchronous reset mid-slot with an event pending.
    ready_a = 1'b0;
    keys_a[9] = 1'b1;
    wait_for(0, 70, "arst_valid", n);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_col_out", col_a, 4'hF);
    chk("arst_valid", valid_a, 0);
    chk("arst_code", code_a, 0);
    chk("arst_held", held_a, 0);
    chk("arst_multi", multi_a, 0);
    chk("arst_overflow", ovf_a, 0);
    keys_a = '0;
    ready_a = 1'b1;
    #20;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_restart_col0", col_a, 4'hE);
    tick(4);
    chk("arst_next_col1", col_a, 4'hD);

    tick(10);
    chk("queue_a_empty", exp_q.size(), 0);
    chk("rep_no_overflow", ovf_b, 0);
    chk("rep_no_multi", multi_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
